uart_imem_loader: RTL and testbench

- Boot-time loader sitting between the UART receiver and the instruction memory's Wishbone slave port.
- Consumes the UART's received-byte strobe stream and parses a framed program image.
- Assembles little-endian 32-bit words and writes them into imem over a Wishbone classic master.
- Holds the core in reset until the image is loaded and its checksum verifies.

---
 rtl/uart_imem_loader.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// Boot-time loader: parses a framed program image from the UART byte stream and
// writes it into instruction memory over a Wishbone classic master, holding the core until done.
module uart_imem_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MAX_WORDS  = 4096,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_core_hold
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t        state_r;
  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   fill_r;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [7:0]    fifo_dout_s;
  logic          pop_s;
  logic          push_s;
  logic          overflow_s;
  logic [15:0]   len_s;
  logic [15:0]   count_r;
  logic [15:0]   word_idx_r;
  logic [1:0]    byte_idx_r;
  logic [23:0]   word_r;
  logic [7:0]    csum_r;
  logic          wb_cyc_r;
  logic          wb_stb_r;
  logic          wb_we_r;
  logic [31:0]   wb_adr_r;
  logic [31:0]   wb_dat_r;
  logic [3:0]    wb_sel_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic          hold_r;

  assign fifo_full_s  = (fill_r == FULL_LVL);
  assign fifo_empty_s = (fill_r == {(AW+1){1'b0}});
  assign fifo_dout_s  = fifo_mem_r[rd_ptr_r];
  assign len_s        = {fifo_dout_s, count_r[7:0]};

  // FSM consumes one byte per cycle in every parsing state; WRITE leaves the FIFO to absorb arrivals
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_ERR: pop_s = !fifo_empty_s;
      default:                                       pop_s = 1'b0;
    endcase
  end

  // Push decision; a full FIFO without a simultaneous pop loses the byte and flags overflow
  always_comb begin
    push_s     = 1'b0;
    overflow_s = 1'b0;
    if (i_rx_valid && (state_r != S_DONE)) begin
      if (fifo_full_s && !pop_s) begin
        overflow_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s     = 1'b0;
      overflow_s = 1'b0;
    end
  end

  // Byte FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= i_rx_data;
    end
  end

  // Byte FIFO pointers and fill level
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      fill_r   <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({push_s, pop_s})
        2'b10:   fill_r <= fill_r + {{AW{1'b0}}, 1'b1};
        2'b01:   fill_r <= fill_r - {{AW{1'b0}}, 1'b1};
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Frame parser and Wishbone master with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      count_r    <= 16'd0;
      word_idx_r <= 16'd0;
      byte_idx_r <= 2'd0;
      word_r     <= 24'd0;
      csum_r     <= 8'd0;
      wb_cyc_r   <= 1'b0;
      wb_stb_r   <= 1'b0;
      wb_we_r    <= 1'b0;
      wb_adr_r   <= 32'd0;
      wb_dat_r   <= 32'd0;
      wb_sel_r   <= 4'h0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      hold_r     <= 1'b1;
    end else if (overflow_s) begin
      // Overflow aborts any write in flight; the slave's late ack is ignored in ERR
      state_r  <= S_ERR;
      wb_cyc_r <= 1'b0;
      wb_stb_r <= 1'b0;
      wb_we_r  <= 1'b0;
      wb_sel_r <= 4'h0;
      busy_r   <= 1'b0;
      err_r    <= 1'b1;
      hold_r   <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE, S_ERR: begin
          if (pop_s && (fifo_dout_s == SYNC_BYTE)) begin
            state_r <= S_LEN0;
            csum_r  <= 8'd0;
            busy_r  <= 1'b1;
            err_r   <= 1'b0;
          end
        end
        S_LEN0: begin
          if (pop_s) begin
            count_r[7:0] <= fifo_dout_s;
            state_r      <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (pop_s) begin
            count_r <= len_s;
            if ({16'd0, len_s} > $unsigned(MAX_WORDS)) begin
              state_r <= S_ERR;
              busy_r  <= 1'b0;
              err_r   <= 1'b1;
            end else if (len_s == 16'd0) begin
              state_r <= S_CSUM;
            end else begin
              state_r    <= S_DATA;
              byte_idx_r <= 2'd0;
              word_idx_r <= 16'd0;
            end
          end
        end
        S_DATA: begin
          if (pop_s) begin
            csum_r     <= csum_add(csum_r, fifo_dout_s);
            word_r     <= {fifo_dout_s, word_r[23:8]};
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              state_r  <= S_WRITE;
              wb_cyc_r <= 1'b1;
              wb_stb_r <= 1'b1;
              wb_we_r  <= 1'b1;
              wb_sel_r <= 4'hF;
              wb_adr_r <= BASE_ADDR + {14'd0, word_idx_r, 2'b00};
              wb_dat_r <= {fifo_dout_s, word_r};
            end
          end
        end
        S_WRITE: begin
          if (i_wb_ack) begin
            wb_cyc_r   <= 1'b0;
            wb_stb_r   <= 1'b0;
            wb_we_r    <= 1'b0;
            wb_sel_r   <= 4'h0;
            word_idx_r <= word_idx_r + 16'd1;
            byte_idx_r <= 2'd0;
            if ((word_idx_r + 16'd1) == count_r) begin
              state_r <= S_CSUM;
            end else begin
              state_r <= S_DATA;
            end
          end
        end
        S_CSUM: begin
          if (pop_s) begin
            busy_r <= 1'b0;
            if (fifo_dout_s == csum_r) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
              hold_r  <= 1'b0;
            end else begin
              state_r <= S_ERR;
              err_r   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_r <= S_DONE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign o_wb_cyc    = wb_cyc_r;
  assign o_wb_stb    = wb_stb_r;
  assign o_wb_we     = wb_we_r;
  assign o_wb_adr    = wb_adr_r;
  assign o_wb_dat    = wb_dat_r;
  assign o_wb_sel    = wb_sel_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_err       = err_r;
  assign o_core_hold = hold_r;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: Wishbone slave with programmable ack delay,
// scoreboard of expected writes, status checks after each frame.
module tb_uart_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          MAXW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        busy, done, err, core_hold;

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;
  logic ack_block = 1'b0;
  int wait_cnt = 0;
  int cyc_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  uart_imem_loader #(
    .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
    .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .i_wb_ack(wb_ack), .o_busy(busy),
    .o_done(done), .o_err(err), .o_core_hold(core_hold)
  );

  assign wb_ack = wb_cyc && wb_stb && !ack_block && (wait_cnt >= ack_delay);

  // Slave wait-state counter
  always @(posedge clk) begin
    if (wb_cyc && wb_stb && !wb_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each acknowledged write against the oldest expectation
  always @(negedge clk) begin
    if (wb_cyc) cyc_cnt <= cyc_cnt + 1;
    if (wb_cyc && wb_stb && wb_ack) begin
      chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wb_adr", 64'(wb_adr), 64'(e[63:32]));
        chk("wb_dat", 64'(wb_dat), 64'(e[31:0]));
        chk("wb_sel", 64'(wb_sel), 64'hF);
        chk("wb_we", 64'(wb_we), 64'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_load(input logic [31:0] words[$], input int gap,
                           input logic expect_wr, input logic [7:0] csum_xor);
    logic [7:0] cs;
    logic [7:0] b;
    logic [15:0] n;
    cs = 8'd0;
    n = 16'(words.size());
    send_byte(8'hA5, gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int i = 0; i < words.size(); i++) begin
      if (expect_wr) exp_q.push_back({BASE + 32'(4 * i), words[i]});
      for (int k = 0; k < 4; k++) begin
        b  = words[i][8*k +: 8];
        cs = cs + b;
        send_byte(b, gap);
      end
    end
    send_byte(cs ^ csum_xor, gap);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ack_block = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_status(input string tag);
    int n;
    n = 0;
    repeat (8) @(negedge clk);
    while (!(done || err) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_settled"}, 64'(done || err), 64'd1);
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e, input logic h);
    chk({tag, "_done"}, 64'(done), 64'(d));
    chk({tag, "_err"}, 64'(err), 64'(e));
    chk({tag, "_hold"}, 64'(core_hold), 64'(h));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    int c0;
    reset = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset values
    chk("rst_cyc", 64'(wb_cyc), 64'd0);
    chk("rst_stb", 64'(wb_stb), 64'd0);
    chk("rst_we", 64'(wb_we), 64'd0);
    chk("rst_adr", 64'(wb_adr), 64'd0);
    chk("rst_dat", 64'(wb_dat), 64'd0);
    chk("rst_sel", 64'(wb_sel), 64'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b1);

    // Good two-word frame, zero-wait ack
    w = '{32'h12345678, 32'hDEADBEEF};
    send_load(w, 1, 1'b1, 8'h00);
    wait_status("good");
    chk_status("good", 1'b1, 1'b0, 1'b0);

    // Bytes after DONE are discarded
    c0 = cyc_cnt;
    w = '{32'h44332211};
    send_load(w, 1, 1'b0, 8'h00);
    repeat (10) @(negedge clk);
    chk_status("done_discard", 1'b1, 1'b0, 1'b0);
    chk("done_no_cyc", 64'(cyc_cnt - c0), 64'd0);

    // Bad checksum, then recovery by resending without reset
    do_reset();
    w = '{32'h12345678, 32'hDEADBEEF};
    send_load(w, 1, 1'b1, 8'h01);
    wait_status("badcs");
    chk_status("badcs", 1'b0, 1'b1, 1'b1);
    send_load(w, 1, 1'b1, 8'h00);
    wait_status("resend");
    chk_status("resend", 1'b1, 1'b0, 1'b0);

    // FIFO overflow: slow slave, back-to-back bytes
    do_reset();
    ack_delay = 20;
    send_load(w, 1, 1'b0, 8'h00);
    wait_status("ovf");
    chk_status("ovf", 1'b0, 1'b1, 1'b1);
    chk("ovf_cyc_dropped", 64'(wb_cyc), 64'd0);

    // Same slow slave, bytes spaced 10 cycles apart
    do_reset();
    send_load(w, 10, 1'b1, 8'h00);
    wait_status("slow");
    chk_status("slow", 1'b1, 1'b0, 1'b0);
    ack_delay = 0;

    // Leading garbage ignored
    do_reset();
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h13, 1);
    w = '{32'h44332211};
    send_load(w, 2, 1'b1, 8'h00);
    wait_status("garbage");
    chk_status("garbage", 1'b1, 1'b0, 1'b0);

    // Count above MAX_WORDS rejected right after LEN1, no bus cycle
    do_reset();
    c0 = cyc_cnt;
    send_byte(8'hA5, 1);
    send_byte(8'h11, 1);
    send_byte(8'h00, 1);
    repeat (2) @(negedge clk);
    chk_status("toolong", 1'b0, 1'b1, 1'b1);
    chk("toolong_no_cyc", 64'(cyc_cnt - c0), 64'd0);

    // Count exactly MAX_WORDS accepted
    do_reset();
    w.delete();
    for (int i = 0; i < MAXW; i++) w.push_back($urandom());
    send_load(w, 2, 1'b1, 8'h00);
    wait_status("maxw");
    chk_status("maxw", 1'b1, 1'b0, 1'b0);

    // Zero-length image
    do_reset();
    c0 = cyc_cnt;
    w.delete();
    send_load(w, 1, 1'b0, 8'h00);
    wait_status("zero");
    chk_status("zero", 1'b1, 1'b0, 1'b0);
    chk("zero_no_cyc", 64'(cyc_cnt - c0), 64'd0);

    // Reset while a write is stalled
    do_reset();
    ack_block = 1'b1;
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    send_byte(8'h44, 1);
    for (int i = 0; i < 20 && !wb_stb; i++) @(negedge clk);
    chk("midrst_stb_before", 64'(wb_stb), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cyc", 64'(wb_cyc), 64'd0);
    chk("midrst_stb", 64'(wb_stb), 64'd0);
    chk("midrst_hold", 64'(core_hold), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    ack_block = 1'b0;
    w = '{32'hCAFEF00D, 32'h0BADC0DE};
    send_load(w, 1, 1'b1, 8'h00);
    wait_status("after_rst");
    chk_status("after_rst", 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
